// File: rtl/phy_tx_ps.sv
// phy_tx_ps: parallel-to-serial transmit PHY.
// After reset the block sends SYNC_FRAMES comma-only frames, then enters ACTIVE and
// accepts one 32-bit word per frame via a ready/valid handshake, shifting it out MSB first.
// When no word is offered at a frame boundary an idle (comma) frame is sent instead.
//
// Ports:
//   clk_32f      - bit clock, one serial bit per rising edge
//   reset_L      - synchronous active-low reset
//   data_in      - parallel word to transmit
//   valid_in     - data_in holds a word to send
//   ready_out    - one-cycle pulse in the last bit cycle of a frame where a word may be taken
//   data_out_SP  - registered serial output, MSB first
//   active_out   - high while in the ACTIVE state
//   idle_out     - high while the frame being shifted out is a comma frame
module phy_tx_ps #(
   parameter int unsigned SYNC_FRAMES = 2,
   parameter logic [7:0]  COMMA       = 8'hBC
) (
   input  logic        clk_32f,
   input  logic        reset_L,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        data_out_SP,
   output logic        active_out,
   output logic        idle_out
);

   localparam logic [31:0] IdleFrame = {4{COMMA}};
   localparam logic [3:0]  LastSync  = 4'(SYNC_FRAMES - 1);

   typedef enum logic [1:0] {StReset, StSync, StActive} state_e;

   state_e      state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  frame_cnt_q, frame_cnt_d;
   logic [31:0] frame_q, frame_d;
   logic        ready_q, ready_d;
   logic        data_q, data_d;
   logic        active_q, active_d;
   logic        idle_q, idle_d;
   logic        wrap;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      frame_cnt_d = frame_cnt_q;
      frame_d     = frame_q;
      idle_d      = idle_q;
      wrap        = (bit_cnt_q == 5'd31);

      unique case (state_q)
         StReset: begin
            state_d     = StSync;
            frame_d     = IdleFrame;
            bit_cnt_d   = 5'd0;
            frame_cnt_d = 4'd0;
            idle_d      = 1'b1;
         end
         StSync, StActive: begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (wrap) begin
               // A word is only taken on the edge that closes a ready cycle.
               if (ready_q && valid_in) begin
                  frame_d = data_in;
                  idle_d  = 1'b0;
               end else begin
                  frame_d = IdleFrame;
                  idle_d  = 1'b1;
               end
               if (state_q == StSync) begin
                  frame_cnt_d = frame_cnt_q + 4'd1;
                  if (frame_cnt_q == LastSync) begin
                     state_d = StActive;
                  end
               end
            end
         end
         default: state_d = StReset;
      endcase

      // Registered outputs are derived from the next state so they line up with it.
      ready_d  = (bit_cnt_d == 5'd31) &&
                 ((state_d == StActive) || ((state_d == StSync) && (frame_cnt_d == LastSync)));
      data_d   = frame_d[~bit_cnt_d];
      active_d = (state_d == StActive);
   end

   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         state_q     <= StReset;
         bit_cnt_q   <= 5'd0;
         frame_cnt_q <= 4'd0;
         frame_q     <= 32'd0;
         ready_q     <= 1'b0;
         data_q      <= 1'b0;
         active_q    <= 1'b0;
         idle_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         frame_q     <= frame_d;
         ready_q     <= ready_d;
         data_q      <= data_d;
         active_q    <= active_d;
         idle_q      <= idle_d;
      end
   end

   assign ready_out   = ready_q;
   assign data_out_SP = data_q;
   assign active_out  = active_q;
   assign idle_out    = idle_q;

endmodule

// File: tb/tb_phy_tx_ps.sv
// Testbench for phy_tx_ps: directed scenarios plus random traffic, checked every cycle
// against a timeline model (cycles since reset release decide sync/active and frame slots).
module tb_phy_tx_ps;

   localparam int unsigned SF = 2;
   localparam logic [31:0] IDLE = 32'hBCBCBCBC;

   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic [31:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_out, data_out_SP, active_out, idle_out;

   phy_tx_ps #(.SYNC_FRAMES(SF), .COMMA(8'hBC)) dut (
      .clk_32f    (clk),
      .reset_L    (reset_L),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .data_out_SP(data_out_SP),
      .active_out (active_out),
      .idle_out   (idle_out)
   );

   always #5 clk = ~clk;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   // Model state: t counts edges since reset release; the frame is chosen at each slot start.
   int          t = 0;
   logic [31:0] m_frame = '0;
   logic        m_idle = 1'b0;
   logic        e_bit = 1'b0, e_rdy = 1'b0, e_act = 1'b0, e_idle = 1'b0;
   logic [63:0] cap = '0;

   task automatic model_edge();
      int pos;
      if (!reset_L) begin
         t = 0; m_frame = '0; m_idle = 1'b0;
         e_bit = 1'b0; e_rdy = 1'b0; e_act = 1'b0; e_idle = 1'b0;
      end else begin
         if (t == 0) begin
            m_frame = IDLE; m_idle = 1'b1;
         end else if (e_rdy) begin
            m_frame = valid_in ? data_in : IDLE;
            m_idle  = !valid_in;
         end
         t++;
         pos    = (t - 1) % 32;
         e_bit  = m_frame[31 - pos];
         e_act  = (t > 32 * SF);
         e_rdy  = (pos == 31) && (t >= 32 * SF);
         e_idle = m_idle;
      end
   endtask

   task automatic cycle(input logic rst, input logic v, input logic [31:0] d, input string tag);
      logic [3:0] obs, exp;
      reset_L  = rst;
      valid_in = v;
      data_in  = d;
      @(posedge clk);
      model_edge();
      #1;
      obs = {data_out_SP, ready_out, active_out, idle_out};
      exp = {e_bit, e_rdy, e_act, e_idle};
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s t=%0d {bit,rdy,act,idle} got=%b want=%b", tag, t, obs, exp);
      end
      cap = {cap[62:0], data_out_SP};
   endtask

   // Idle until the model expects a ready pulse; the next edge is a load edge.
   task automatic wait_rdy(input string tag);
      int n = 0;
      while (!e_rdy && n < 40) begin
         cycle(1'b1, 1'b0, $urandom, tag);
         n++;
      end
      nvec++;
      assert (e_rdy) else begin
         nerr++;
         $error("FAIL %s_timeout got=no_ready want=ready", tag);
      end
   endtask

   task automatic check_word(input logic [31:0] got, input logic [31:0] want, input string tag);
      nvec++;
      assert (got === want) else begin
         nerr++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   initial begin
      // Held reset: everything zero and X-free on every edge.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, $urandom, "reset_hold");

      // Sync sequence: 64 comma bits, ready only in cycle 64, active on edge 65.
      for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, $urandom, "sync");
      check_word(cap[63:32], IDLE, "sync_frame1");
      check_word(cap[31:0], IDLE, "sync_frame2");

      // One word after sync, then idle.
      wait_rdy("w1_wait");
      cycle(1'b1, 1'b1, 32'h12345678, "w1");
      for (int i = 0; i < 31; i++) cycle(1'b1, 1'b0, $urandom, "w1");
      check_word(cap[31:0], 32'h12345678, "w1_bits");
      for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, $urandom, "w1_idle");
      check_word(cap[31:0], IDLE, "w1_idle_bits");

      // Back-to-back words with valid held high.
      wait_rdy("b2b_wait");
      cycle(1'b1, 1'b1, 32'hA5A5A5A5, "b2b");
      for (int i = 0; i < 63; i++)
         cycle(1'b1, 1'b1, e_rdy ? 32'h0000FFFF : $urandom, "b2b");
      check_word(cap[63:32], 32'hA5A5A5A5, "b2b_w0");
      check_word(cap[31:0], 32'h0000FFFF, "b2b_w1");

      // Comma-valued data goes out as data.
      wait_rdy("comma_wait");
      cycle(1'b1, 1'b1, IDLE, "comma_data");
      for (int i = 0; i < 31; i++) cycle(1'b1, 1'b0, $urandom, "comma_data");
      check_word(cap[31:0], IDLE, "comma_bits");

      // Reset in the middle of a data frame, then a full resync with valid offered.
      wait_rdy("mid_wait");
      cycle(1'b1, 1'b1, 32'hDEADBEEF, "mid_data");
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, $urandom, "mid_data");
      cycle(1'b0, 1'b1, $urandom, "mid_reset");
      for (int i = 0; i < 66; i++) cycle(1'b1, 1'b1, $urandom, "resync");

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++)
         cycle(($urandom % 300) != 0, $urandom_range(0, 1) == 1, $urandom, "random");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
